// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC register with a direct-mapped branch predictor.
// Each table entry pairs a 2-bit saturating direction counter with a
// branch target. The next fetch PC comes from reset, an execute redirect,
// a stall hold, a taken prediction, or sequential +4, in that priority.
module fetch_pc_predictor #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          ENTRIES  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        bp_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispred,
    output logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] branch_count,
    output logic [31:0] mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Predictor table: valid/ctr are control state, tag/target are data.
    logic               entry_valid  [ENTRIES];
    logic [1:0]         entry_ctr    [ENTRIES];
    logic [TAG_W-1:0]   entry_tag    [ENTRIES];
    logic [31:0]        entry_target [ENTRIES];

    logic [IDX_W-1:0]   fetch_idx;
    logic [TAG_W-1:0]   fetch_tag;
    logic               fetch_hit;
    logic [31:0]        seq_pc;

    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;

    // Byte-offset bits never select an entry; instructions are word aligned.
    logic               unused_pc_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

    // Lookup for the current fetch PC; zero-latency prediction.
    always_comb begin
        fetch_idx   = fetch_pc[IDX_W+1:2];
        fetch_tag   = fetch_pc[31:IDX_W+2];
        seq_pc      = fetch_pc + 32'd4;
        fetch_hit   = entry_valid[fetch_idx] && (entry_tag[fetch_idx] == fetch_tag);
        pred_taken  = bp_enable && fetch_hit && entry_ctr[fetch_idx][1];
        pred_target = fetch_hit ? entry_target[fetch_idx] : seq_pc;
    end

    // Lookup of the entry addressed by the resolved branch.
    always_comb begin
        upd_idx = update_pc[IDX_W+1:2];
        upd_tag = update_pc[31:IDX_W+2];
        upd_hit = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);
    end

    // Next-PC selection: reset > redirect > stall > prediction > +4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (!stall) begin
            fetch_pc <= pred_taken ? pred_target : seq_pc;
        end
    end

    // Table control state and statistics; training ignores stall/redirect/bp_enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i] <= 1'b0;
                entry_ctr[i]   <= 2'b01;
            end
            branch_count  <= 32'd0;
            mispred_count <= 32'd0;
        end else if (update_valid) begin
            branch_count <= branch_count + 32'd1;
            if (update_mispred) begin
                mispred_count <= mispred_count + 32'd1;
            end
            if (upd_hit) begin
                entry_ctr[upd_idx] <= update_taken ? sat_inc(entry_ctr[upd_idx])
                                                   : sat_dec(entry_ctr[upd_idx]);
            end else if (update_taken) begin
                entry_valid[upd_idx] <= 1'b1;
                entry_ctr[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target payload; only meaningful once valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (update_valid && update_taken) begin
            entry_tag[upd_idx]    <= upd_tag;
            entry_target[upd_idx] <= update_target;
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor with hand-computed expectations.
module tb_fetch_pc_predictor;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        bp_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispred;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    int vec_count = 0;
    int err_count = 0;

    fetch_pc_predictor #(.RESET_PC(32'h4000_0000), .ENTRIES(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .bp_enable      (bp_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .update_mispred (update_mispred),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .branch_count   (branch_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        // Second reset cycle with a competing redirect and update; both must be dropped.
        redirect_valid = 1'b1; redirect_pc = 32'h1234_5670;
        update_valid = 1'b1; update_pc = 32'h4000_0000; update_taken = 1'b1;
        update_target = 32'h4000_0800; update_mispred = 1'b1;
        step();
        redirect_valid = 1'b0; update_valid = 1'b0; update_taken = 1'b0; update_mispred = 1'b0;
        #1;
        vec_count++;
        if (fetch_pc !== 32'h4000_0000) begin err_count++; $display("FAIL reset_pc: got %h expected %h", fetch_pc, 32'h4000_0000); end
        vec_count++;
        if (pred_taken !== 1'b0) begin err_count++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
        vec_count++;
        if (pred_target !== 32'h4000_0004) begin err_count++; $display("FAIL reset_pred_target: got %h expected %h", pred_target, 32'h4000_0004); end
        vec_count++;
        if (branch_count !== 32'd0 || mispred_count !== 32'd0) begin err_count++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", branch_count, mispred_count); end
        rst_n = 1'b1;
        step();
        vec_count++;
        if (fetch_pc !== 32'h4000_0004 || pred_taken !== 1'b0) begin err_count++; $display("FAIL seq_1: got %h/%b expected 40000004/0", fetch_pc, pred_taken); end
        step();
        vec_count++;
        if (fetch_pc !== 32'h4000_0008 || pred_taken !== 1'b0) begin err_count++; $display("FAIL seq_2: got %h/%b expected 40000008/0", fetch_pc, pred_taken); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vec_count++;
            if (fetch_pc !== 32'h4000_0008) begin err_count++; $display("FAIL stall_hold_%0d: got %h expected %h", i, fetch_pc, 32'h4000_0008); end
        end
        redirect_to(32'h4000_0100);
        vec_count++;
        if (fetch_pc !== 32'h4000_0100) begin err_count++; $display("FAIL redirect_over_stall: got %h expected %h", fetch_pc, 32'h4000_0100); end
        stall = 1'b0;
    endtask

    task automatic test_train_predict();
        // Train and redirect to the trained PC in the same cycle.
        update_valid = 1'b1; update_pc = 32'h4000_0010; update_taken = 1'b1; update_target = 32'h4000_0200;
        redirect_valid = 1'b1; redirect_pc = 32'h4000_0010;
        step();
        update_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        vec_count++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h4000_0200) begin err_count++; $display("FAIL train_pred: got %b/%h expected 1/40000200", pred_taken, pred_target); end
        vec_count++;
        if (branch_count !== 32'd1) begin err_count++; $display("FAIL train_branch_count: got %0d expected 1", branch_count); end
        step();
        vec_count++;
        if (fetch_pc !== 32'h4000_0200) begin err_count++; $display("FAIL follow_pred: got %h expected %h", fetch_pc, 32'h4000_0200); end
        // Two not-taken updates: ctr 10 -> 01 -> 00.
        update_valid = 1'b1; update_taken = 1'b0;
        step();
        step();
        update_valid = 1'b0;
        redirect_to(32'h4000_0010);
        vec_count++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h4000_0200) begin err_count++; $display("FAIL untrained: got %b/%h expected 0/40000200", pred_taken, pred_target); end
        step();
        vec_count++;
        if (fetch_pc !== 32'h4000_0014) begin err_count++; $display("FAIL untrained_seq: got %h expected %h", fetch_pc, 32'h4000_0014); end
        vec_count++;
        if (branch_count !== 32'd3) begin err_count++; $display("FAIL branch_count_3: got %0d expected 3", branch_count); end
    endtask

    task automatic test_saturation_enable();
        // From ctr=00: five taken -> 01,10,11,11,11; one not-taken -> 10.
        update_valid = 1'b1; update_pc = 32'h4000_0010; update_taken = 1'b1; update_target = 32'h4000_0300;
        for (int i = 0; i < 5; i++) step();
        update_taken = 1'b0;
        step();
        update_valid = 1'b0;
        redirect_to(32'h4000_0010);
        vec_count++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h4000_0300) begin err_count++; $display("FAIL saturate_pred: got %b/%h expected 1/40000300", pred_taken, pred_target); end
        step();
        vec_count++;
        if (fetch_pc !== 32'h4000_0300) begin err_count++; $display("FAIL saturate_follow: got %h expected %h", fetch_pc, 32'h4000_0300); end
        bp_enable = 1'b0;
        redirect_to(32'h4000_0010);
        vec_count++;
        if (pred_taken !== 1'b0) begin err_count++; $display("FAIL bp_disable_pred: got %b expected 0", pred_taken); end
        step();
        vec_count++;
        if (fetch_pc !== 32'h4000_0014) begin err_count++; $display("FAIL bp_disable_seq: got %h expected %h", fetch_pc, 32'h4000_0014); end
        bp_enable = 1'b1;
    endtask

    task automatic test_alias();
        redirect_to(32'h4000_0110);
        vec_count++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h4000_0114) begin err_count++; $display("FAIL alias_miss: got %b/%h expected 0/40000114", pred_taken, pred_target); end
        update_valid = 1'b1; update_pc = 32'h4000_0110; update_taken = 1'b1; update_target = 32'h4000_0500;
        redirect_valid = 1'b1; redirect_pc = 32'h4000_0010;
        step();
        update_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        vec_count++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h4000_0014) begin err_count++; $display("FAIL alias_evicted: got %b/%h expected 0/40000014", pred_taken, pred_target); end
        redirect_to(32'h4000_0110);
        vec_count++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h4000_0500) begin err_count++; $display("FAIL alias_new: got %b/%h expected 1/40000500", pred_taken, pred_target); end
        vec_count++;
        if (branch_count !== 32'd10 || mispred_count !== 32'd0) begin err_count++; $display("FAIL alias_counters: got %0d/%0d expected 10/0", branch_count, mispred_count); end
    endtask

    task automatic test_counters_wrap();
        // Reset while stalled clears counters and PC.
        stall = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1; stall = 1'b0;
        #1;
        vec_count++;
        if (fetch_pc !== 32'h4000_0000 || branch_count !== 32'd0) begin err_count++; $display("FAIL reset_mid_stall: got %h/%0d expected 40000000/0", fetch_pc, branch_count); end
        update_pc = 32'h4000_0800; update_taken = 1'b0;
        for (int i = 0; i < 10; i++) begin
            update_valid   = 1'b1;
            update_mispred = (i == 1 || i == 4 || i == 7);
            step();
        end
        update_valid = 1'b0; update_mispred = 1'b1;
        step();
        update_mispred = 1'b0;
        #1;
        vec_count++;
        if (branch_count !== 32'd10) begin err_count++; $display("FAIL branch_count_10: got %0d expected 10", branch_count); end
        vec_count++;
        if (mispred_count !== 32'd3) begin err_count++; $display("FAIL mispred_count_3: got %0d expected 3", mispred_count); end
        redirect_to(32'hFFFF_FFFC);
        vec_count++;
        if (fetch_pc !== 32'hFFFF_FFFC || pred_target !== 32'h0000_0000) begin err_count++; $display("FAIL wrap_target: got %h/%h expected fffffffc/00000000", fetch_pc, pred_target); end
        step();
        vec_count++;
        if (fetch_pc !== 32'h0000_0000) begin err_count++; $display("FAIL wrap_pc: got %h expected 00000000", fetch_pc); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; bp_enable = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        update_valid = 1'b0; update_pc = 32'd0; update_taken = 1'b0;
        update_target = 32'd0; update_mispred = 1'b0;
        test_reset();
        test_stall_redirect();
        test_train_predict();
        test_saturation_enable();
        test_alias();
        test_counters_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
